hazard_ctl: RTL and testbench
=============================

Name: hazard_ctl

Overview:
- Pipeline hazard controller; the stall/flush side of the hazard logic, complementing the EX-stage forwarding unit.
- Covers the cases that forwarding cannot resolve:
  - load-use dependency → single bubble;
  - data-memory busy → whole-pipe freeze;
  - taken branch resolved in ID → IF/ID flush;
  - HLT → PC freeze, pipeline drain, then halted.
- Sits beside the ID stage; drives the PC and pipeline-register enables and flushes.

Parameters:
- LW_OP, 4'h8, load-word opcode.
- HLT_OP, 4'hF, halt opcode.
- DRAIN_CYC, 4, cycles from HLT leaving ID until `halted` asserts.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifid_op  in  4  opcode of instruction in ID.
- ifid_rs  in  4  ID source register rs.
- ifid_rt  in  4  ID source register rt.
- idex_op  in  4  opcode in ID/EX.
- idex_rd  in  4  destination register in ID/EX.
- br_taken  in  1  ID branch resolved taken.
- mem_busy  in  1  data memory not ready; pipe must freeze.
- pc_hold  out  1  PC write disable.
- ifid_hold  out  1  IF/ID write disable.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_bubble  out  1  ID/EX loads NOP (control zeroed).
- pipe_freeze  out  1  ID/EX, EX/MEM, MEM/WB write disable.
- halted  out  1  registered; processor fully stopped.

Behaviour:
- Source usage by ifid_op:
  - 0xC (B), 0xE (PCS), 0xF (HLT): no sources.
  - 0xD (BR): rs only.
  - All others: rs and rt.
- Register 0 is not special-cased.
- ldu (load-use hazard) = (idex_op==LW_OP) & ((uses_rs & idex_rd==ifid_rs) | (uses_rt & idex_rd==ifid_rt)).
- All control outputs are combinational from state + inputs (Mealy). Only state, drain_cnt and halted are registered.
- States: RUN, MWAIT, DRAIN, HALT. Reset → RUN, drain_cnt=0, halted=0. All outputs are 0 in RUN with no events.
- RUN, priority order mem_busy > ldu > HLT in ID > br_taken:
  - mem_busy=1:
    - pc_hold=ifid_hold=pipe_freeze=1.
    - Next state MWAIT.
    - ldu, br_taken and HLT are ignored this cycle.
  - ldu=1:
    - pc_hold=ifid_hold=idex_bubble=1.
    - br_taken is masked, since the branch re-evaluates next cycle.
    - Stay in RUN. Exactly one bubble results, because the bubble removes LW from ID/EX.
  - ifid_op==HLT_OP:
    - pc_hold=1 and ifid_flush=1.
    - Next state DRAIN, drain_cnt loads DRAIN_CYC-1.
  - br_taken=1: ifid_flush=1, stay in RUN.
- MWAIT:
  - While mem_busy=1: pc_hold=ifid_hold=pipe_freeze=1.
  - When mem_busy=0: outputs are evaluated exactly as in RUN that same cycle, and next state is RUN.
  - The wait has no timeout.
- DRAIN:
  - pc_hold=1, ifid_flush=1.
  - mem_busy=1: pipe_freeze=1 and drain_cnt holds.
  - Otherwise drain_cnt decrements. At drain_cnt==0 with mem_busy=0 → HALT, and halted=1 from the next edge.
- HALT: pc_hold=ifid_hold=1, pipe_freeze=1, halted=1. Exited only by reset.
- br_taken in DRAIN or HALT is ignored.
- rst asserted in any state: immediate return to RUN with all registered outputs 0. Combinational outputs follow the RUN equations.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs ldu_cnt[15:0], mwait_cnt[15:0], flush_cnt[15:0], all reset to 0.
  - Per-cycle increments:
    - ldu_cnt: cycles with idex_bubble=1.
    - mwait_cnt: cycles with pipe_freeze=1 outside HALT.
    - flush_cnt: cycles with ifid_flush=1 due to br_taken.
  - Counters saturate at 16'hFFFF and freeze once halted=1.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- ldu on rt: idex_op=8, idex_rd=3, ifid_op=0 (ADD), ifid_rt=3 → pc_hold=ifid_hold=idex_bubble=1 for exactly 1 cycle. Next cycle idex_op=0 → all outputs 0.
- No hazard for B: idex_op=8, idex_rd=3, ifid_op=C, ifid_rs=3 → no bubble. With br_taken=1 → ifid_flush=1 only.
- BR, load-use plus taken branch: ifid_op=D, ifid_rs=5, idex_op=8, idex_rd=5, br_taken=1 → idex_bubble=1, ifid_flush=0.
- Memory freeze: mem_busy high 3 cycles in RUN with a concurrent ldu → pipe_freeze=pc_hold=ifid_hold=1 for 3 cycles, idex_bubble=0. On release, idex_bubble=1 that same cycle.
- Halt with memory stall: ifid_op=F, then mem_busy=1 for 2 cycles during DRAIN → halted rises exactly DRAIN_CYC+2 cycles after HLT was in ID. pc_hold stays 1 from HLT-in-ID onward.
- Async reset: assert rst mid-DRAIN, off-edge → halted=0 and state RUN immediately. With HAZARD_PERF_CNT_EN defined, all counters read 0.

Source files
------------

// File: rtl/hazard_ctl.sv
// hazard_ctl: stall/flush half of the pipeline hazard logic, sitting beside ID.
// Handles load-use bubbles, data-memory freezes, taken-branch flushes and the
// HLT drain/halt sequence. Control outputs are Mealy (state + inputs); only
// state, drain_cnt and halted are registered.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating performance counters
// ldu_cnt, mwait_cnt and flush_cnt.

module hazard_ctl #(
  parameter logic [3:0] LW_OP     = 4'h8,
  parameter logic [3:0] HLT_OP    = 4'hF,
  parameter int         DRAIN_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ifid_op,
  input  logic [3:0]  ifid_rs,
  input  logic [3:0]  ifid_rt,
  input  logic [3:0]  idex_op,
  input  logic [3:0]  idex_rd,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_freeze,
  output logic        halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] ldu_cnt,
  output logic [15:0] mwait_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, MWAIT, DRAIN, HALT} state_t;

  state_t     state, state_next;
  logic [3:0] drain_cnt, drain_cnt_next;
  logic       halted_next;
  logic       uses_rs, uses_rt, ldu;
  logic       run_eval;
  logic       br_flush;

  // Decode which source registers the ID instruction actually reads, then
  // detect a load whose destination feeds one of them.
  always_comb begin
    uses_rs = !((ifid_op == 4'hC) || (ifid_op == 4'hE) || (ifid_op == 4'hF));
    uses_rt = uses_rs && (ifid_op != 4'hD);
    ldu     = (idex_op == LW_OP) &&
              ((uses_rs && (idex_rd == ifid_rs)) || (uses_rt && (idex_rd == ifid_rt)));
  end

  // Next-state and Mealy control outputs. Leaving MWAIT reuses the full RUN
  // evaluation (including an HLT that arrived during the wait) so no event
  // seen on the release cycle is dropped.
  always_comb begin
    pc_hold        = 1'b0;
    ifid_hold      = 1'b0;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    pipe_freeze    = 1'b0;
    br_flush       = 1'b0;
    state_next     = state;
    drain_cnt_next = drain_cnt;
    halted_next    = halted;
    run_eval       = (state == RUN) || ((state == MWAIT) && !mem_busy);

    if (run_eval) begin
      state_next = RUN;
      if (mem_busy) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        pipe_freeze = 1'b1;
        state_next  = MWAIT;
      end else if (ldu) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end else if (ifid_op == HLT_OP) begin
        pc_hold        = 1'b1;
        ifid_flush     = 1'b1;
        state_next     = DRAIN;
        drain_cnt_next = 4'(DRAIN_CYC - 1);
      end else if (br_taken) begin
        ifid_flush = 1'b1;
        br_flush   = 1'b1;
      end
    end else begin
      case (state)
        MWAIT: begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          pipe_freeze = 1'b1;
        end
        DRAIN: begin
          pc_hold    = 1'b1;
          ifid_flush = 1'b1;
          if (mem_busy) begin
            pipe_freeze = 1'b1;
          end else if (drain_cnt == 4'd0) begin
            state_next  = HALT;
            halted_next = 1'b1;
          end else begin
            drain_cnt_next = drain_cnt - 4'd1;
          end
        end
        HALT: begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          pipe_freeze = 1'b1;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // State, drain counter and halted flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= 4'd0;
      halted    <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      halted    <= halted_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters, frozen once the processor has halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldu_cnt   <= 16'd0;
      mwait_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else if (!halted) begin
      if (idex_bubble && (ldu_cnt != 16'hFFFF))
        ldu_cnt <= ldu_cnt + 16'd1;
      if (pipe_freeze && (state != HALT) && (mwait_cnt != 16'hFFFF))
        mwait_cnt <= mwait_cnt + 16'd1;
      if (br_flush && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Testbench for hazard_ctl: directed vectors push expected outputs into a
// scoreboard queue; a monitor pops and compares on each falling edge.
// Expected vector bit order: {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze, halted}.

module tb_hazard_ctl;

  logic       clk;
  logic       rst;
  logic [3:0] ifid_op, ifid_rs, ifid_rt, idex_op, idex_rd;
  logic       br_taken, mem_busy;
  logic       pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze, halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] ldu_cnt, mwait_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];

  hazard_ctl dut (
    .clk         (clk),
    .rst         (rst),
    .ifid_op     (ifid_op),
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt),
    .idex_op     (idex_op),
    .idex_rd     (idex_rd),
    .br_taken    (br_taken),
    .mem_busy    (mem_busy),
    .pc_hold     (pc_hold),
    .ifid_hold   (ifid_hold),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .pipe_freeze (pipe_freeze),
    .halted      (halted)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .ldu_cnt     (ldu_cnt),
    .mwait_cnt   (mwait_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the expected outputs.
  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [3:0] rs,
                               input logic [3:0] rt, input logic [3:0] iop, input logic [3:0] ird,
                               input logic br, input logic mb, input logic [5:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    ifid_op  = op;
    ifid_rs  = rs;
    ifid_rt  = rt;
    idex_op  = iop;
    idex_rd  = ird;
    br_taken = br;
    mem_busy = mb;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // Pulse reset between clock edges with idle inputs; outputs must drop to the RUN idle values at once.
  task automatic applyResetPulse(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    ifid_op  = 4'h0;
    ifid_rs  = 4'h0;
    ifid_rt  = 4'h0;
    idex_op  = 4'h0;
    idex_rd  = 4'h0;
    br_taken = 1'b0;
    mem_busy = 1'b0;
    e.exp  = 6'b000000;
    e.name = name;
    sb.push_back(e);
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
`ifdef HAZARD_PERF_CNT_EN
    checkOutput({name, "_cnt"}, {ldu_cnt, mwait_cnt, flush_cnt}, 48'd0);
`endif
    rst = 1'b0;
  endtask

  // Monitor: every falling edge with a pending expectation is one comparison.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e.name, {42'd0, pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze, halted},
                    {42'd0, e.exp});
      end
    end
  end

  initial begin
    rst      = 1'b1;
    ifid_op  = 4'h0;
    ifid_rs  = 4'h0;
    ifid_rt  = 4'h0;
    idex_op  = 4'h0;
    idex_rd  = 4'h0;
    br_taken = 1'b0;
    mem_busy = 1'b0;

    applyStimulus("reset_state", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 6'b000000);
    @(negedge clk);
    #1 rst = 1'b0;

    applyStimulus("idle",         4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 6'b000000);
    applyStimulus("ldu_rt",       4'h0, 4'h1, 4'h3, 4'h8, 4'h3, 1'b0, 1'b0, 6'b110100);
    applyStimulus("ldu_rt_after", 4'h0, 4'h1, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 6'b000000);
    applyStimulus("ldu_rs",       4'h0, 4'h4, 4'h0, 4'h8, 4'h4, 1'b0, 1'b0, 6'b110100);
    applyStimulus("lw_no_match",  4'h0, 4'h1, 4'h2, 4'h8, 4'h3, 1'b0, 1'b0, 6'b000000);
    applyStimulus("non_lw_match", 4'h0, 4'h3, 4'h3, 4'h1, 4'h3, 1'b0, 1'b0, 6'b000000);
    applyStimulus("b_no_src",     4'hC, 4'h3, 4'h3, 4'h8, 4'h3, 1'b0, 1'b0, 6'b000000);
    applyStimulus("b_taken",      4'hC, 4'h3, 4'h3, 4'h8, 4'h3, 1'b1, 1'b0, 6'b001000);
    applyStimulus("pcs_no_src",   4'hE, 4'h3, 4'h3, 4'h8, 4'h3, 1'b0, 1'b0, 6'b000000);
    applyStimulus("br_rt_unused", 4'hD, 4'h1, 4'h5, 4'h8, 4'h5, 1'b0, 1'b0, 6'b000000);
    applyStimulus("br_ldu_taken", 4'hD, 4'h5, 4'h0, 4'h8, 4'h5, 1'b1, 1'b0, 6'b110100);
    applyStimulus("ldu_reg0",     4'h0, 4'h0, 4'h7, 4'h8, 4'h0, 1'b0, 1'b0, 6'b110100);

    // Memory freeze over a pending load-use, released with the hazard still present.
    applyStimulus("mwait_1",      4'h0, 4'h1, 4'h3, 4'h8, 4'h3, 1'b0, 1'b1, 6'b110010);
    applyStimulus("mwait_2",      4'h0, 4'h1, 4'h3, 4'h8, 4'h3, 1'b1, 1'b1, 6'b110010);
    applyStimulus("mwait_3",      4'h0, 4'h1, 4'h3, 4'h8, 4'h3, 1'b0, 1'b1, 6'b110010);
    applyStimulus("mwait_rel",    4'h0, 4'h1, 4'h3, 4'h8, 4'h3, 1'b0, 1'b0, 6'b110100);
    applyStimulus("mwait_clear",  4'h0, 4'h1, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 6'b000000);

    // HLT with a two-cycle memory stall in the drain: halted rises DRAIN_CYC+2 edges later.
    applyStimulus("hlt_in_id",    4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 6'b101000);
    applyStimulus("drain_1",      4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 6'b101000);
    applyStimulus("drain_busy1",  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 6'b101010);
    applyStimulus("drain_busy2",  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 6'b101010);
    applyStimulus("drain_2_br",   4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 6'b101000);
    applyStimulus("drain_3",      4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 6'b101000);
    applyStimulus("drain_4",      4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 6'b101000);
    applyStimulus("halt_1",       4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 6'b110011);
    applyStimulus("halt_2",       4'h0, 4'h1, 4'h3, 4'h8, 4'h3, 1'b0, 1'b1, 6'b110011);

    applyResetPulse("reset_from_halt");
    applyStimulus("post_reset_br", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 6'b001000);

    // Second halt, interrupted by an off-edge reset in the middle of the drain.
    applyStimulus("hlt2_in_id",   4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 6'b101000);
    applyStimulus("hlt2_drain",   4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 6'b101000);
    applyResetPulse("reset_mid_drain");
    applyStimulus("after_reset",  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 6'b000000);
    applyStimulus("after_rst_br", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 6'b001000);
    applyStimulus("after_rst_ldu",4'h0, 4'h2, 4'h0, 4'h8, 4'h2, 1'b0, 1'b0, 6'b110100);

    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_scoreboard: pending %0d expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
